// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation codes and immediate formats,
// plus the small decode helpers used by the decode stage.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // FENCE and SYSTEM carry I-format fields even though they execute as NOPs.
    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OPC_JALR, OPC_LOAD, OPC_OPIMM,
            OPC_FENCE, OPC_SYSTEM:       return IMM_I;
            OPC_STORE:                   return IMM_S;
            OPC_BRANCH:                  return IMM_B;
            OPC_LUI, OPC_AUIPC:          return IMM_U;
            OPC_JAL:                     return IMM_J;
            default:                     return IMM_NONE;
        endcase
    endfunction

    // alt turns ADD into SUB and SRL into SRA.
    function automatic alu_op_e alu_op_of(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the format from the opcode and
// returns the sign-extended 32-bit immediate.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_fmt_of(inst[6:0]))
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes one instruction per handshake, reads the register
// file with writeback bypass, and registers the result into ID/EX.
module id_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_ready,
    output logic [4:0]  o_r1addr,
    output logic [4:0]  o_r2addr,
    input  logic [31:0] i_r1data,
    input  logic [31:0] i_r2data,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic        i_flush,
    input  logic        i_ex_ready,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_imm,
    output logic [31:0] o_rs1val,
    output logic [31:0] o_rs2val,
    output logic [4:0]  o_rd,
    output logic        o_rd_we,
    output logic [3:0]  o_alu_op,
    output logic        o_alu_src_imm,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic        o_is_branch,
    output logic        o_is_jal,
    output logic        o_is_jalr,
    output logic        o_is_auipc,
    output logic [2:0]  o_funct3,
    output logic        o_illegal
);

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic [31:0] rs1val, rs2val;

    logic    dec_illegal, dec_load, dec_store, dec_branch;
    logic    dec_jal, dec_jalr, dec_auipc, dec_writes, dec_src_imm;
    logic    rs1_used, rs2_used;
    alu_op_e dec_alu;

    logic hazard, adv, load_slot;

    assign opcode   = i_inst[6:0];
    assign rd       = i_inst[11:7];
    assign funct3   = i_inst[14:12];
    assign rs1      = i_inst[19:15];
    assign rs2      = i_inst[24:20];
    assign o_r1addr = rs1;
    assign o_r2addr = rs2;

    imm_gen u_imm_gen (
        .inst (i_inst),
        .imm  (imm)
    );

    always_comb begin
        dec_illegal = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_branch  = 1'b0;
        dec_jal     = 1'b0;
        dec_jalr    = 1'b0;
        dec_auipc   = 1'b0;
        dec_writes  = 1'b0;
        dec_src_imm = 1'b0;
        dec_alu     = ALU_ADD;
        rs1_used    = 1'b1;
        rs2_used    = 1'b0;
        case (opcode)
            OPC_LUI:    begin dec_writes = 1'b1; dec_src_imm = 1'b1; dec_alu = ALU_PASSB; rs1_used = 1'b0; end
            OPC_AUIPC:  begin dec_writes = 1'b1; dec_src_imm = 1'b1; dec_auipc = 1'b1;    rs1_used = 1'b0; end
            OPC_JAL:    begin dec_writes = 1'b1; dec_src_imm = 1'b1; dec_jal = 1'b1;      rs1_used = 1'b0; end
            OPC_JALR:   begin dec_writes = 1'b1; dec_src_imm = 1'b1; dec_jalr = 1'b1; end
            OPC_BRANCH: begin dec_branch = 1'b1; rs2_used = 1'b1; end
            OPC_LOAD:   begin dec_writes = 1'b1; dec_src_imm = 1'b1; dec_load = 1'b1; end
            OPC_STORE:  begin dec_store = 1'b1; dec_src_imm = 1'b1; rs2_used = 1'b1; end
            OPC_OPIMM:  begin
                dec_writes  = 1'b1;
                dec_src_imm = 1'b1;
                // Only the shift-right form of OP-IMM has an alternate encoding.
                dec_alu     = alu_op_of(funct3, i_inst[30] && (funct3 == 3'b101));
            end
            OPC_OP:     begin dec_writes = 1'b1; rs2_used = 1'b1; dec_alu = alu_op_of(funct3, i_inst[30]); end
            OPC_FENCE, OPC_SYSTEM: ;
            default:    dec_illegal = 1'b1;
        endcase
    end

    assign rs1val = (i_wb_addr != 5'd0 && i_wb_addr == rs1) ? i_wb_data : i_r1data;
    assign rs2val = (i_wb_addr != 5'd0 && i_wb_addr == rs2) ? i_wb_data : i_r2data;

    assign hazard = o_valid && o_is_load && (o_rd != 5'd0) &&
                    ((rs1_used && rs1 == o_rd) || (rs2_used && rs2 == o_rd));
    assign adv       = !o_valid || i_ex_ready;
    assign o_ready   = i_flush || (adv && !hazard);
    assign load_slot = adv && !hazard && i_valid;

    // Flush, bubbles and empty slots clear only the side-effecting flags; data fields may keep stale values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_pc          <= RESET_PC;
            o_imm         <= '0;
            o_rs1val      <= '0;
            o_rs2val      <= '0;
            o_rd          <= '0;
            o_rd_we       <= 1'b0;
            o_alu_op      <= '0;
            o_alu_src_imm <= 1'b0;
            o_is_load     <= 1'b0;
            o_is_store    <= 1'b0;
            o_is_branch   <= 1'b0;
            o_is_jal      <= 1'b0;
            o_is_jalr     <= 1'b0;
            o_is_auipc    <= 1'b0;
            o_funct3      <= '0;
            o_illegal     <= 1'b0;
        end else if (i_flush || (adv && !load_slot)) begin
            o_valid     <= 1'b0;
            o_rd_we     <= 1'b0;
            o_is_load   <= 1'b0;
            o_is_store  <= 1'b0;
            o_is_branch <= 1'b0;
            o_is_jal    <= 1'b0;
            o_is_jalr   <= 1'b0;
            o_is_auipc  <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (load_slot) begin
            o_valid       <= 1'b1;
            o_pc          <= i_pc;
            o_imm         <= imm;
            o_rs1val      <= rs1val;
            o_rs2val      <= rs2val;
            o_rd          <= rd;
            o_rd_we       <= dec_writes && (rd != 5'd0) && !dec_illegal;
            o_alu_op      <= dec_alu;
            o_alu_src_imm <= dec_src_imm;
            o_is_load     <= dec_load;
            o_is_store    <= dec_store;
            o_is_branch   <= dec_branch;
            o_is_jal      <= dec_jal;
            o_is_jalr     <= dec_jalr;
            o_is_auipc    <= dec_auipc;
            o_funct3      <= funct3;
            o_illegal     <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a behavioural ID/EX model checked every
// negedge, plus directed vectors with hand-computed expectations.
module tb_id_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic        i_clk, i_rst, i_valid, i_flush, i_ex_ready;
    logic [31:0] i_inst, i_pc, i_r1data, i_r2data, i_wb_data;
    logic [4:0]  i_wb_addr;
    logic        o_ready, o_valid, o_rd_we, o_alu_src_imm;
    logic        o_is_load, o_is_store, o_is_branch, o_is_jal, o_is_jalr, o_is_auipc, o_illegal;
    logic [4:0]  o_r1addr, o_r2addr, o_rd;
    logic [31:0] o_pc, o_imm, o_rs1val, o_rs2val;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_funct3;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] regs [32];

    id_stage #(.RESET_PC(RST_PC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
        .o_ready(o_ready), .o_r1addr(o_r1addr), .o_r2addr(o_r2addr),
        .i_r1data(i_r1data), .i_r2data(i_r2data), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_valid(o_valid), .o_pc(o_pc),
        .o_imm(o_imm), .o_rs1val(o_rs1val), .o_rs2val(o_rs2val), .o_rd(o_rd), .o_rd_we(o_rd_we),
        .o_alu_op(o_alu_op), .o_alu_src_imm(o_alu_src_imm), .o_is_load(o_is_load),
        .o_is_store(o_is_store), .o_is_branch(o_is_branch), .o_is_jal(o_is_jal),
        .o_is_jalr(o_is_jalr), .o_is_auipc(o_is_auipc), .o_funct3(o_funct3), .o_illegal(o_illegal)
    );

    assign i_r1data = regs[o_r1addr];
    assign i_r2data = regs[o_r2addr];

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic [31:0] pc, imm, rs1val, rs2val;
        logic [4:0]  rd;
        logic        rd_we;
        logic [3:0]  alu_op;
        logic        src_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_auipc;
        logic [2:0]  funct3;
        logic        illegal;
    } exp_t;

    function automatic bool_rs1_reader(input logic [31:0] inst);
        return !(inst[6:0] inside {7'h37, 7'h17, 7'h6F});
    endfunction

    function automatic bool_rs2_reader(input logic [31:0] inst);
        return inst[6:0] inside {7'h63, 7'h23, 7'h33};
    endfunction

    function automatic logic [31:0] readReg(input logic [4:0] r, input logic [4:0] wba, input logic [31:0] wbd);
        if (wba != 5'd0 && wba == r) return wbd;
        return (r == 5'd0) ? 32'd0 : regs[r];
    endfunction

    // Spec-level decode: instruction class first, then each field from the class.
    function automatic exp_t expectFields(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic [4:0] wba, input logic [31:0] wbd);
        exp_t e;
        logic signed [31:0] t;
        logic [3:0] baseOp [8];
        baseOp = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        e = '0;
        e.pc = pc;
        e.rd = inst[11:7];
        e.funct3 = inst[14:12];
        e.rs1val = readReg(inst[19:15], wba, wbd);
        e.rs2val = readReg(inst[24:20], wba, wbd);
        e.alu_op = 4'd0;
        case (inst[6:0])
            7'h37: begin t = 32'(inst[31:12]) <<< 12; e.alu_op = 4'd10; e.rd_we = 1; e.src_imm = 1; end
            7'h17: begin t = 32'(inst[31:12]) <<< 12; e.is_auipc = 1; e.rd_we = 1; e.src_imm = 1; end
            7'h6F: begin t = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21]})) * 2;
                         e.is_jal = 1; e.rd_we = 1; e.src_imm = 1; end
            7'h67: begin t = 32'($signed(inst[31:20])); e.is_jalr = 1; e.rd_we = 1; e.src_imm = 1; end
            7'h63: begin t = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8]})) * 2; e.is_branch = 1; end
            7'h03: begin t = 32'($signed(inst[31:20])); e.is_load = 1; e.rd_we = 1; e.src_imm = 1; end
            7'h23: begin t = 32'($signed({inst[31:25], inst[11:7]})); e.is_store = 1; e.src_imm = 1; end
            7'h13: begin
                t = 32'($signed(inst[31:20]));
                e.rd_we = 1; e.src_imm = 1;
                e.alu_op = baseOp[inst[14:12]];
                if (inst[14:12] == 3'd5 && inst[30]) e.alu_op = 4'd7;
            end
            7'h33: begin
                t = 0;
                e.rd_we = 1;
                e.alu_op = baseOp[inst[14:12]];
                if (inst[30] && inst[14:12] == 3'd0) e.alu_op = 4'd1;
                if (inst[30] && inst[14:12] == 3'd5) e.alu_op = 4'd7;
            end
            7'h0F, 7'h73: t = 32'($signed(inst[31:20]));
            default: begin t = 0; e.illegal = 1; end
        endcase
        e.imm = t;
        if (e.rd == 5'd0) e.rd_we = 0;
        return e;
    endfunction

    logic mValid = 1'b0;
    exp_t mExp = '0;

    function automatic logic modelHazard();
        logic [31:0] inst;
        inst = i_inst;
        return mValid && mExp.is_load && mExp.rd != 5'd0 &&
               ((bool_rs1_reader(inst) && inst[19:15] == mExp.rd) ||
                (bool_rs2_reader(inst) && inst[24:20] == mExp.rd));
    endfunction

    function automatic logic modelReady();
        return i_flush || ((!mValid || i_ex_ready) && !modelHazard());
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mValid <= 1'b0;
        end else if (i_flush) begin
            mValid <= 1'b0;
        end else if (!mValid || i_ex_ready) begin
            if (modelHazard() || !i_valid) begin
                mValid <= 1'b0;
            end else begin
                mValid <= 1'b1;
                mExp   <= expectFields(i_inst, i_pc, i_wb_addr, i_wb_data);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        checkOutput("valid", 32'(o_valid), 32'(mValid));
        checkOutput("ready", 32'(o_ready), 32'(modelReady()));
        checkOutput("r1addr", 32'(o_r1addr), 32'(i_inst[19:15]));
        checkOutput("r2addr", 32'(o_r2addr), 32'(i_inst[24:20]));
        if (mValid) begin
            checkOutput("pc", o_pc, mExp.pc);
            checkOutput("imm", o_imm, mExp.imm);
            checkOutput("rs1val", o_rs1val, mExp.rs1val);
            checkOutput("rs2val", o_rs2val, mExp.rs2val);
            checkOutput("rd", 32'(o_rd), 32'(mExp.rd));
            checkOutput("rd_we", 32'(o_rd_we), 32'(mExp.rd_we));
            checkOutput("alu_op", 32'(o_alu_op), 32'(mExp.alu_op));
            checkOutput("src_imm", 32'(o_alu_src_imm), 32'(mExp.src_imm));
            checkOutput("flags", {26'd0, o_is_load, o_is_store, o_is_branch, o_is_jal, o_is_jalr, o_is_auipc},
                        {26'd0, mExp.is_load, mExp.is_store, mExp.is_branch, mExp.is_jal, mExp.is_jalr, mExp.is_auipc});
            checkOutput("funct3", 32'(o_funct3), 32'(mExp.funct3));
            checkOutput("illegal", 32'(o_illegal), 32'(mExp.illegal));
        end else begin
            checkOutput("empty_flags", {26'd0, o_rd_we, o_is_load, o_is_store, o_is_branch, o_is_jal, o_is_jalr}, 32'd0);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic fl, input logic exr);
        i_valid    = v;
        i_inst     = inst;
        i_flush    = fl;
        i_ex_ready = exr;
    endtask

    logic [31:0] pcCount = RST_PC;

    // Present inst until accepted; tries reports how many cycles it took.
    task automatic issue(input logic [31:0] inst, output int tries);
        logic acc;
        tries = 0;
        i_valid = 1'b1;
        i_inst  = inst;
        i_pc    = pcCount;
        do begin
            #1;
            acc = o_ready;
            step();
            tries++;
        end while (!acc && tries < 10);
        if (!acc) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL issue_timeout: got ready=0 for 10 cycles, expected acceptance, inst 0x%08h", inst);
        end
        pcCount = pcCount + 32'd4;
    endtask

    int tries;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
        regs[0] = 32'd0;
        regs[3] = 32'd0;
        i_rst = 1'b1;
        i_pc = 32'd0;
        i_wb_addr = 5'd0;
        i_wb_data = 32'd0;
        applyStimulus(1'b0, 32'h0000_0013, 1'b0, 1'b1);
        step();
        checkOutput("reset_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_pc", o_pc, RST_PC);
        checkOutput("reset_ready", 32'(o_ready), 32'd1);
        checkOutput("reset_imm", o_imm, 32'd0);
        i_rst = 1'b0;
        step();

        // ADDI x1,x0,-5
        issue(32'hFFB0_0093, tries);
        i_valid = 1'b0;
        checkOutput("addi_valid", 32'(o_valid), 32'd1);
        checkOutput("addi_imm", o_imm, 32'hFFFF_FFFB);
        checkOutput("addi_rd", 32'(o_rd), 32'd1);
        checkOutput("addi_rd_we", 32'(o_rd_we), 32'd1);
        checkOutput("addi_alu", 32'(o_alu_op), 32'd0);
        checkOutput("addi_src_imm", 32'(o_alu_src_imm), 32'd1);

        // LW x5,0(x2) then ADD x6,x5,x1: one bubble
        issue(32'h0001_2283, tries);
        i_inst = 32'h0012_8333;
        #1;
        checkOutput("loaduse_ready0", 32'(o_ready), 32'd0);
        issue(32'h0012_8333, tries);
        checkOutput("loaduse_tries", 32'(tries), 32'd2);
        checkOutput("loaduse_rd", 32'(o_rd), 32'd6);

        // Writeback bypass onto rs1=x3, then x0 never bypassed
        i_wb_addr = 5'd3;
        i_wb_data = 32'hDEAD_BEEF;
        issue(32'h0011_8393, tries);
        checkOutput("bypass_rs1", o_rs1val, 32'hDEAD_BEEF);
        i_wb_addr = 5'd0;
        issue(32'h0000_0413, tries);
        checkOutput("x0_rs1", o_rs1val, 32'd0);
        i_wb_data = 32'd0;

        // SUB x9,x1,x2 then stall EX for 3 cycles with flush in the 2nd
        issue(32'h4020_84B3, tries);
        checkOutput("sub_alu", 32'(o_alu_op), 32'd1);
        i_pc = pcCount;
        applyStimulus(1'b1, 32'h1234_55B7, 1'b0, 1'b0);
        #1;
        checkOutput("stall_ready", 32'(o_ready), 32'd0);
        step();
        checkOutput("stall_hold_rd", 32'(o_rd), 32'd9);
        checkOutput("stall_hold_valid", 32'(o_valid), 32'd1);
        applyStimulus(1'b1, 32'h1234_55B7, 1'b1, 1'b0);
        step();
        checkOutput("flush_valid", 32'(o_valid), 32'd0);
        applyStimulus(1'b1, 32'h1234_55B7, 1'b0, 1'b0);
        step();
        checkOutput("lui_imm", o_imm, 32'h1234_5000);
        i_ex_ready = 1'b1;
        pcCount = pcCount + 32'd4;

        // BEQ x1,x2,-4 ; JAL x0,8 ; illegal opcode 0x7F
        issue(32'hFE20_8EE3, tries);
        checkOutput("beq_imm", o_imm, 32'hFFFF_FFFC);
        checkOutput("beq_branch", 32'(o_is_branch), 32'd1);
        issue(32'h0080_006F, tries);
        checkOutput("jal_x0_rd_we", 32'(o_rd_we), 32'd0);
        checkOutput("jal_imm", o_imm, 32'd8);
        issue(32'h0000_00FF, tries);
        checkOutput("illegal_flag", 32'(o_illegal), 32'd1);
        checkOutput("illegal_rd_we", 32'(o_rd_we), 32'd0);

        // Back-to-back mix checked by the model: SRAI, SW, AUIPC, JALR, FENCE, SLTU
        issue(32'h4030_D513, tries);
        checkOutput("srai_alu", 32'(o_alu_op), 32'd7);
        issue(32'h0020_A223, tries);
        checkOutput("sw_imm", o_imm, 32'd4);
        issue(32'h0000_1617, tries);
        issue(32'h0002_80E7, tries);
        issue(32'h0000_000F, tries);
        issue(32'h0020_B5B3, tries);

        // Flush with an instruction presented discards it
        i_pc = pcCount;
        applyStimulus(1'b1, 32'h0010_0093, 1'b1, 1'b1);
        step();
        checkOutput("flush_discard", 32'(o_valid), 32'd0);
        applyStimulus(1'b0, 32'h0000_0013, 1'b0, 1'b1);
        step();

        // Asynchronous reset mid-cycle with a live instruction
        issue(32'hFFB0_0093, tries);
        i_valid = 1'b0;
        i_ex_ready = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("async_valid", 32'(o_valid), 32'd0);
        checkOutput("async_pc", o_pc, RST_PC);
        step();
        step();
        i_rst = 1'b0;
        i_ex_ready = 1'b1;
        pcCount = RST_PC;
        issue(32'h0000_0413, tries);
        i_valid = 1'b0;
        checkOutput("after_reset_pc", o_pc, RST_PC);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the rv32i pipeline. It takes one fetched instruction per handshake, drives the register file's two read ports, and bypasses the same-cycle writeback value. It also generates the immediate and control fields. Results are registered into the ID/EX pipeline register, with load-use stall and branch-flush handling.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value loaded into o_pc on reset.

Ports:
- i_clk  in  1  clock. One clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  fetch presents an instruction.
- i_inst  in  32  instruction word.
- i_pc  in  32  instruction address.
- o_ready  out  1  combinational; the instruction is accepted when i_valid && o_ready.
- o_r1addr, o_r2addr  out  5  register file read addresses, equal to i_inst[19:15] and i_inst[24:20].
- i_r1data, i_r2data  in  32  register file read data (combinational, x0 reads 0).
- i_wb_addr  in  5  writeback destination; 0 means no write (the register file has no write enable).
- i_wb_data  in  32  writeback data.
- i_flush  in  1  redirect from EX.
- i_ex_ready  in  1  EX accepts the ID/EX register contents.
- o_valid  out  1  ID/EX register holds a live instruction.
- o_pc, o_imm, o_rs1val, o_rs2val  out  32  registered operands.
- o_rd  out  5  destination register.
- o_rd_we  out  1  destination write enable; forced to 0 when rd==0.
- o_alu_op  out  4  ALU operation code.
- o_alu_src_imm  out  1  ALU operand B is the immediate.
- o_is_load, o_is_store, o_is_branch, o_is_jal, o_is_jalr, o_is_auipc  out  1 each  instruction class flags.
- o_funct3  out  3  passed through for memory size and branch condition.
- o_illegal  out  1  opcode not in the RV32I base set; o_rd_we is 0 in that case.

## Operation
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (treated as NOP), SYSTEM (treated as NOP). Any other opcode sets o_illegal.
- Immediate formats: I, S, B, U and J, each sign-extended to 32 bits.
  - B and J immediates have bit 0 = 0.
  - U immediate is inst[31:12] followed by 12 zero bits.
- Bypass: if i_wb_addr != 0 and i_wb_addr == rsN, then rsNval takes i_wb_data; otherwise it takes i_rNdata.
- Register use:
  - rs1 is used by all classes except LUI, AUIPC and JAL.
  - rs2 is used only by BRANCH, STORE and OP.
- Hazard condition: o_valid && o_is_load && o_rd != 0 && (rs1 used and rs1 == o_rd, or rs2 used and rs2 == o_rd).
- Register advance: the ID/EX register advances when adv = !o_valid || i_ex_ready.
- o_ready = i_flush || (adv && !hazard).
- Next-state priority, highest first:
  1. i_flush: o_valid <= 0. The input instruction is discarded, whether or not it was presented.
  2. adv && hazard: o_valid <= 0 (bubble). The input is not accepted.
  3. adv && i_valid: load the register, o_valid <= 1.
  4. adv && !i_valid: o_valid <= 0.
  5. Otherwise (EX stalled): hold every field.
- When a bubble or empty slot is loaded, the data fields may take any value, but o_rd_we, o_is_load, o_is_store, o_is_branch, o_is_jal and o_is_jalr must be 0.

## Timing
- Latency: one cycle from acceptance to o_valid.
- Throughput: one instruction per cycle with no hazard.
- Reset values: o_valid 0, o_pc RESET_PC, and every other output 0. o_ready follows its combinational equation during and after reset.
- Load-use: exactly one bubble cycle. After the bubble, the load sits in EX, so the dependent instruction is no longer a hazard against it. Forwarding from MEM is done downstream.
- Reset asserted mid-stall returns the block to the reset state immediately. The held instruction is lost, and fetch re-presents from the reset PC.

## Structure
- Shared package rv32i_pkg:
  - opcode constants
  - ALU op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10
  - immediate-format enum
- Sub-module imm_gen: combinational, inst → 32-bit immediate. Everything else lives in id_stage.
- ALU op mapping:
  - funct7[5] selects SUB/SRA on OP, and SRA only on OP-IMM.
  - LUI uses PASSB.
  - AUIPC, JAL, JALR, LOAD and STORE use ADD.

## Test plan
- ADDI x1,x0,-5 (0xFFB00093) with i_ex_ready=1 → next cycle o_valid=1, o_imm=0xFFFFFFFB, o_rd=1, o_rd_we=1, o_alu_op=ADD, o_alu_src_imm=1.
- LW x5,0(x2) accepted, then ADD x6,x5,x1 presented → o_ready=0 for one cycle and a bubble is loaded. The ADD is accepted on the following cycle.
- i_wb_addr=3, i_wb_data=0xDEADBEEF, instruction reads rs1=x3 while i_r1data=0 → o_rs1val=0xDEADBEEF. Repeat with i_wb_addr=0 and an instruction reading x0 → o_rs1val=0.
- i_ex_ready=0 for 3 cycles with a valid register → all outputs held and o_ready=0. Assert i_flush in the 2nd cycle → o_valid=0 on the next edge.
- BEQ with offset -4 → o_imm=0xFFFFFFFC and o_is_branch=1. JAL x0 → o_rd_we=0. Opcode 0x7F → o_illegal=1 and o_rd_we=0.
- Assert i_rst asynchronously mid-cycle with o_valid=1 → o_valid=0 and o_pc=RESET_PC without waiting for a clock edge.
